// File: rtl/mod241_chunk_reducer.sv
// mod241_chunk_reducer
// Serial Horner reducer: takes a wide operand as 6-bit chunks, most
// significant chunk first, and returns the operand modulo 241. It is the
// low-area counterpart and golden cross-check of the parallel LUT bank.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     in_data/in_last hold a chunk
//   in_ready     block can accept a chunk this cycle (state only)
//   in_data      6-bit chunk, MSB chunk of the frame first
//   in_last      sender marks the final chunk of the frame
//   out_valid    out_residue/out_err are valid
//   out_ready    consumer takes the result
//   out_residue  operand mod 241 (0..240)
//   out_err      frame length disagreed with NUM_CHUNKS
module mod241_chunk_reducer #(
  parameter int NUM_CHUNKS = 84,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_residue,
  output logic       out_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_cntLast;
  logic             w_frameEnd;
  logic             w_outTaken;
  logic [13:0]      w_wide;
  logic [10:0]      w_fold1;
  logic [8:0]       w_fold2;
  logic [7:0]       w_accNext;

  // Handshake qualifiers. A frame closes on the first accepted chunk that is
  // either flagged last by the sender or lands in the final counter slot.
  always_comb begin
    w_accept   = in_valid & in_ready;
    w_cntLast  = (r_cnt == CNT_W'(NUM_CHUNKS - 1));
    w_frameEnd = w_accept & (in_last | w_cntLast);
    w_outTaken = out_valid & out_ready;
  end

  // One Horner step, acc*64 + chunk, reduced exactly mod 241 in one cycle.
  // Since 256 = 15 (mod 241), the bits above bit 7 are folded back in as
  // 15*high + low. Two folds bring the 14-bit value (max 15423) below 316,
  // and a single conditional subtract finishes the reduction.
  always_comb begin
    w_wide    = {r_acc, 6'b0} + {8'd0, in_data};
    w_fold1   = {5'd0, w_wide[13:8]} * 11'd15 + {3'd0, w_wide[7:0]};
    w_fold2   = {6'd0, w_fold1[10:8]} * 9'd15 + {1'b0, w_fold1[7:0]};
    w_accNext = (w_fold2 >= 9'd241) ? 8'(w_fold2 - 9'd241) : w_fold2[7:0];
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: leave ACCUM when a frame closes, leave HOLD when the result
  // is taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ACCUM: if (w_frameEnd) w_nextState = HOLD;
      HOLD:  if (w_outTaken) w_nextState = ACCUM;
      default: w_nextState = ACCUM;
    endcase
  end

  // Handshake outputs depend on state alone, so there is no combinational
  // path from in_valid or out_ready to either of them.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM: in_ready  = 1'b1;
      HOLD:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: accumulator, chunk counter and the result registers. The
  // result registers keep their value after the handshake; consumers only
  // look at them while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= 8'd0;
      r_cnt       <= '0;
      out_residue <= 8'd0;
      out_err     <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_accept) begin
        r_acc <= w_accNext;
        if (w_frameEnd) begin
          out_residue <= w_accNext;
          out_err     <= (in_last != w_cntLast);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end else if (w_outTaken) begin
      r_acc <= 8'd0;
      r_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mod241_chunk_reducer.sv
// Testbench for mod241_chunk_reducer: table of directed frames with
// hand-computed results, hand-written reset sequences, then random frames
// checked against a weighted-sum reference model.
module tb_mod241_chunk_reducer;

  localparam int N = 84;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_residue;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  logic [5:0] chunkBuf [0:N-1];

  typedef struct {
    int kind;
    int len;
    int lastAt;
    bit throttle;
    int hold;
    int expRes;
    int expErr;
  } vec_t;

  vec_t vecs [0:8];

  mod241_chunk_reducer #(.NUM_CHUNKS(N), .CNT_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_residue(out_residue),
    .out_err(out_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single comparison with failure reporting.
  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Operand value mod 241 as the weighted sum of chunks times 64^position.
  function automatic int modelResidue(input int n);
    int r;
    int w;
    r = 0;
    w = 1;
    for (int i = n - 1; i >= 0; i--) begin
      r = (r + int'(chunkBuf[i]) * w) % 241;
      w = (w * 64) % 241;
    end
    return r;
  endfunction

  // Fill the chunk buffer with one of the directed patterns.
  task automatic fillKind(input int kind);
    for (int i = 0; i < N; i++) chunkBuf[i] = 6'd0;
    case (kind)
      1: chunkBuf[83] = 6'd63;
      2: chunkBuf[82] = 6'd1;
      3: begin chunkBuf[81] = 6'd3; chunkBuf[82] = 6'd49; end
      4: for (int i = 0; i < N; i++) chunkBuf[i] = 6'd63;
      5: begin chunkBuf[0] = 6'd1; chunkBuf[1] = 6'd2; chunkBuf[2] = 6'd3; end
      default: ;
    endcase
  endtask

  // Present one chunk until accepted; called and returns at posedge+1.
  task automatic sendChunk(input logic [5:0] d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkVal("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send chunkBuf[0..len-1], in_last on index lastAt, optional idle gaps.
  task automatic applyStimulus(input int len, input int lastAt, input bit throttle);
    for (int i = 0; i < len; i++) begin
      if (throttle) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      sendChunk(chunkBuf[i], (i == lastAt));
    end
  endtask

  // Check the result right after the final accept, stall the consumer for
  // hold cycles, then take the result and check the return to ACCUM.
  task automatic checkOutput(input string tag, input int expRes, input int expErr, input int hold);
    checkVal({tag, "_valid"}, int'(out_valid), 1);
    checkVal({tag, "_residue"}, int'(out_residue), expRes);
    checkVal({tag, "_err"}, int'(out_err), expErr);
    checkVal({tag, "_inready_hold"}, int'(in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      checkVal({tag, "_stall_valid"}, int'(out_valid), 1);
      checkVal({tag, "_stall_residue"}, int'(out_residue), expRes);
      checkVal({tag, "_stall_inready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({tag, "_valid_drop"}, int'(out_valid), 0);
    checkVal({tag, "_inready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{kind: 0, len: 84, lastAt: 83, throttle: 0, hold: 0, expRes: 0,   expErr: 0};
    vecs[1] = '{kind: 1, len: 84, lastAt: 83, throttle: 0, hold: 0, expRes: 63,  expErr: 0};
    vecs[2] = '{kind: 2, len: 84, lastAt: 83, throttle: 0, hold: 0, expRes: 64,  expErr: 0};
    vecs[3] = '{kind: 3, len: 84, lastAt: 83, throttle: 0, hold: 0, expRes: 0,   expErr: 0};
    vecs[4] = '{kind: 4, len: 84, lastAt: 83, throttle: 0, hold: 0, expRes: 0,   expErr: 0};
    vecs[5] = '{kind: 2, len: 84, lastAt: 83, throttle: 1, hold: 0, expRes: 64,  expErr: 0};
    vecs[6] = '{kind: 1, len: 84, lastAt: 83, throttle: 0, hold: 5, expRes: 63,  expErr: 0};
    vecs[7] = '{kind: 5, len: 3,  lastAt: 2,  throttle: 0, hold: 0, expRes: 130, expErr: 1};
    vecs[8] = '{kind: 1, len: 84, lastAt: -1, throttle: 0, hold: 0, expRes: 63,  expErr: 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    checkVal("reset_out_valid", int'(out_valid), 0);
    checkVal("reset_residue", int'(out_residue), 0);
    checkVal("reset_err", int'(out_err), 0);
    checkVal("reset_in_ready", int'(in_ready), 1);

    // Directed table.
    for (int v = 0; v < 9; v++) begin
      fillKind(vecs[v].kind);
      applyStimulus(vecs[v].len, vecs[v].lastAt, vecs[v].throttle);
      checkOutput($sformatf("vec%0d", v), vecs[v].expRes, vecs[v].expErr, vecs[v].hold);
    end

    // Reset in the middle of a frame discards it.
    fillKind(4);
    applyStimulus(40, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkVal("midrst_out_valid", int'(out_valid), 0);
    checkVal("midrst_in_ready", int'(in_ready), 1);
    fillKind(1);
    applyStimulus(84, 83, 1'b0);
    checkOutput("midrst_frame", 63, 0, 0);

    // Reset while holding a result, together with out_ready.
    fillKind(2);
    applyStimulus(84, 83, 1'b0);
    checkVal("holdrst_pre_valid", int'(out_valid), 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    checkVal("holdrst_out_valid", int'(out_valid), 0);
    checkVal("holdrst_in_ready", int'(in_ready), 1);
    fillKind(1);
    applyStimulus(84, 83, 1'b0);
    checkOutput("holdrst_frame", 63, 0, 0);

    // Random frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      int len;
      int lastAt;
      int expErr;
      for (int i = 0; i < N; i++) chunkBuf[i] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        len    = N;
        lastAt = -1;
        expErr = 1;
      end else begin
        len    = $urandom_range(1, N);
        lastAt = len - 1;
        expErr = (len == N) ? 0 : 1;
      end
      applyStimulus(len, lastAt, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", f), modelResidue(len), expErr, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
